nexys_starship_break_sched: RTL and testbench

Central break scheduler for Nexys Starship. It decides when a repair station breaks next and which one, replacing the free-running per-station random break triggers. It issues one-cycle break pulses with a 4-bit repair combo to the repair state machines (top, bottom, left, right), shortens the break interval as play progresses, and raises game-over when every station stays broken too long.

---
 rtl/nexys_starship_pkg.sv | 20 ++
 rtl/nexys_starship_break_sched_if.sv | 29 ++
 rtl/nexys_starship_lfsr.sv | 24 ++
 rtl/nexys_starship_break_sched.sv | 173 +++++++++++++++++
 tb/tb_nexys_starship_break_sched.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the Nexys Starship repair/break logic.
package nexys_starship_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_COUNT = 5'b00010,
    S_PICK  = 5'b00100,
    S_ISSUE = 5'b01000,
    S_OVER  = 5'b10000
  } state_t;

  localparam int ST_TOP   = 0;
  localparam int ST_BTM   = 1;
  localparam int ST_LEFT  = 2;
  localparam int ST_RIGHT = 3;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/nexys_starship_break_sched_if.sv
// Game-control bundle between the break scheduler and the game/display side.
interface nexys_starship_break_sched_if #(
  parameter int N_STATION = 4
);
  logic                 tick;
  logic                 play_flag;
  logic [N_STATION-1:0] broken;
  logic [N_STATION-1:0] break_pulse;
  logic [3:0]           break_hex;
  logic                 gameover_ctrl;
  logic [7:0]           interval;
  logic                 q_Idle;
  logic                 q_Count;
  logic                 q_Pick;
  logic                 q_Issue;
  logic                 q_Over;

  modport master (
    output tick, play_flag, broken,
    input  break_pulse, break_hex, gameover_ctrl, interval,
    input  q_Idle, q_Count, q_Pick, q_Issue, q_Over
  );

  modport slave (
    input  tick, play_flag, broken,
    output break_pulse, break_hex, gameover_ctrl, interval,
    output q_Idle, q_Count, q_Pick, q_Issue, q_Over
  );
endinterface

// File: rtl/nexys_starship_lfsr.sv
// Free-running right-shifting Galois LFSR; a nonzero seed keeps it off the all-zero lockup.
module nexys_starship_lfsr
  import nexys_starship_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MASK  = LFSR_MASK,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= SEED;
    end else if (state[0]) begin
      state <= (state >> 1) ^ MASK;
    end else begin
      state <= state >> 1;
    end
  end

endmodule

// File: rtl/nexys_starship_break_sched.sv
// Central break scheduler: counts game ticks, picks a free station round-robin from a
// random start, issues a one-cycle break pulse, speeds up over time and detects game over.
module nexys_starship_break_sched
  import nexys_starship_pkg::*;
#(
  parameter int N_STATION     = 4,
  parameter int BASE_INTERVAL = 8,
  parameter int MIN_INTERVAL  = 2,
  parameter int LEVEL_STEP    = 4,
  parameter int MAX_BROKEN    = 3,
  parameter int GRACE         = 6
) (
  input  logic Clk,
  input  logic Reset,
  nexys_starship_break_sched_if.slave bus
);

  localparam int               IDX_W      = $clog2(N_STATION);
  localparam int               ISSUE_W    = $clog2(LEVEL_STEP) + 1;
  localparam logic [7:0]       BASE_I     = 8'(BASE_INTERVAL);
  localparam logic [7:0]       MIN_I      = 8'(MIN_INTERVAL);
  localparam logic [7:0]       GRACE_LAST = 8'(GRACE - 1);
  localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(LEVEL_STEP - 1);

  state_t               state_reg;
  logic [7:0]           cnt_reg;
  logic [7:0]           interval_reg;
  logic [7:0]           grace_reg;
  logic [ISSUE_W-1:0]   issue_reg;
  logic [N_STATION-1:0] pulse_reg;
  logic [3:0]           hex_reg;
  logic                 over_reg;

  logic [15:0]          lfsr_state;
  logic                 lfsr_unused;
  logic [IDX_W:0]       free_slot;
  logic                 all_broken;
  logic                 active;
  logic                 grace_expire;
  logic                 can_issue;
  logic [3:0]           hex_pick;
  logic [7:0]           interval_dec;
  logic [N_STATION-1:0] onehot_sel;

  nexys_starship_lfsr #(
    .WIDTH(16),
    .MASK (LFSR_MASK),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk  (Clk),
    .Reset(Reset),
    .state(lfsr_state)
  );

  // Returns {found, index} of the first non-broken station scanning upward from start.
  function automatic logic [IDX_W:0] find_free(input logic [N_STATION-1:0] brk, input int start);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_STATION - 1; k >= 0; k--) begin
      idx = (start + k) % N_STATION;
      if (!brk[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign lfsr_unused = ^{lfsr_state[15:8], lfsr_state[3:2]};

  always_comb begin
    free_slot    = find_free(bus.broken, int'(lfsr_state[1:0]));
    all_broken   = &bus.broken;
    active       = state_reg inside {S_COUNT, S_PICK, S_ISSUE};
    grace_expire = active && bus.tick && all_broken && (grace_reg == GRACE_LAST);
    can_issue    = free_slot[IDX_W] && ($countones(bus.broken) < MAX_BROKEN);
    hex_pick     = (lfsr_state[7:4] == 4'h0) ? 4'hF : lfsr_state[7:4];
    interval_dec = (interval_reg > MIN_I) ? interval_reg - 8'd1 : MIN_I;
    onehot_sel   = N_STATION'(1) << free_slot[IDX_W-1:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      interval_reg <= BASE_I;
      grace_reg    <= '0;
      issue_reg    <= '0;
      pulse_reg    <= '0;
      hex_reg      <= '0;
      over_reg     <= 1'b0;
    end else begin
      pulse_reg <= '0;
      if (active && all_broken) begin
        if (bus.tick) grace_reg <= grace_reg + 8'd1;
      end else begin
        grace_reg <= '0;
      end

      case (state_reg)
        S_IDLE: begin
          over_reg     <= 1'b0;
          interval_reg <= BASE_I;
          issue_reg    <= '0;
          if (bus.play_flag) begin
            state_reg <= S_COUNT;
            cnt_reg   <= BASE_I;
          end
        end
        S_COUNT: begin
          if (!bus.play_flag) begin
            state_reg <= S_IDLE;
          end else if (grace_expire) begin
            state_reg <= S_OVER;
            over_reg  <= 1'b1;
          end else if (bus.tick) begin
            if (cnt_reg > 8'd1) cnt_reg <= cnt_reg - 8'd1;
            else                state_reg <= S_PICK;
          end
        end
        // Game over takes priority over issuing, so a pulse never escapes on the final tick.
        S_PICK: begin
          if (!bus.play_flag) begin
            state_reg <= S_IDLE;
          end else if (grace_expire) begin
            state_reg <= S_OVER;
            over_reg  <= 1'b1;
          end else if (can_issue) begin
            state_reg <= S_ISSUE;
            pulse_reg <= onehot_sel;
            hex_reg   <= hex_pick;
          end else begin
            state_reg <= S_COUNT;
            cnt_reg   <= interval_reg;
          end
        end
        S_ISSUE: begin
          if (issue_reg == ISSUE_LAST) begin
            issue_reg    <= '0;
            interval_reg <= interval_dec;
          end else begin
            issue_reg <= issue_reg + ISSUE_W'(1);
          end
          if (!bus.play_flag) begin
            state_reg <= S_IDLE;
          end else if (grace_expire) begin
            state_reg <= S_OVER;
            over_reg  <= 1'b1;
          end else begin
            state_reg <= S_COUNT;
            cnt_reg   <= (issue_reg == ISSUE_LAST) ? interval_dec : interval_reg;
          end
        end
        S_OVER: begin
          if (!bus.play_flag) begin
            state_reg <= S_IDLE;
            over_reg  <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.break_pulse   = pulse_reg;
  assign bus.break_hex     = hex_reg;
  assign bus.gameover_ctrl = over_reg;
  assign bus.interval      = interval_reg;
  assign bus.q_Idle        = (state_reg == S_IDLE);
  assign bus.q_Count       = (state_reg == S_COUNT);
  assign bus.q_Pick        = (state_reg == S_PICK);
  assign bus.q_Issue       = (state_reg == S_ISSUE);
  assign bus.q_Over        = (state_reg == S_OVER);

endmodule

// File: tb/tb_nexys_starship_break_sched.sv
// Bench for the break scheduler: per-cycle comparison against a behavioural game model
// plus directed scenarios with hand-computed expectations.
module tb_nexys_starship_break_sched;

  localparam int BASE  = 8;
  localparam int MINI  = 2;
  localparam int STEP  = 4;
  localparam int MAXB  = 3;
  localparam int GRACE = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nexys_starship_break_sched_if #(.N_STATION(4)) bus();

  nexys_starship_break_sched #(
    .N_STATION(4), .BASE_INTERVAL(BASE), .MIN_INTERVAL(MINI),
    .LEVEL_STEP(STEP), .MAX_BROKEN(MAXB), .GRACE(GRACE)
  ) dut (
    .Clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_pulses = 0;
  logic [3:0] hit_mask = '0;
  bit         cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 counting ticks, 2 picking, 3 issuing, 4 game over.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int rr_free(input logic [3:0] brk, input logic [1:0] start);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (int'(start) + k) % 4;
      if (!brk[idx]) return idx;
    end
    return -1;
  endfunction

  // Interval follows directly from how many breaks were issued this game.
  function automatic int interval_of(input int issues);
    int v;
    v = BASE - issues / STEP;
    return (v < MINI) ? MINI : v;
  endfunction

  int          m_phase, m_ticks, m_issues, m_grace, m_free;
  logic [15:0] m_lfsr;
  logic [3:0]  m_pulse, m_hex;
  bit          m_expiry;

  always_comb begin
    m_free   = rr_free(bus.broken, m_lfsr[1:0]);
    m_expiry = (m_phase >= 1 && m_phase <= 3) && bus.tick && (bus.broken == 4'hF)
               && (m_grace == GRACE - 1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_ticks <= 0; m_issues <= 0; m_grace <= 0;
      m_lfsr <= 16'hACE1; m_pulse <= '0; m_hex <= '0;
    end else begin
      m_lfsr  <= lfsr_step(m_lfsr);
      m_pulse <= '0;
      if (m_phase >= 1 && m_phase <= 3 && bus.broken == 4'hF) begin
        if (bus.tick) m_grace <= m_grace + 1;
      end else begin
        m_grace <= 0;
      end
      case (m_phase)
        0: begin
          m_issues <= 0;
          if (bus.play_flag) begin m_phase <= 1; m_ticks <= BASE; end
        end
        1: begin
          if (!bus.play_flag) m_phase <= 0;
          else if (m_expiry) m_phase <= 4;
          else if (bus.tick) begin
            if (m_ticks > 1) m_ticks <= m_ticks - 1;
            else m_phase <= 2;
          end
        end
        2: begin
          if (!bus.play_flag) m_phase <= 0;
          else if (m_expiry) m_phase <= 4;
          else if ($countones(bus.broken) < MAXB && m_free >= 0) begin
            m_phase <= 3;
            m_pulse <= 4'(1) << m_free;
            m_hex   <= (m_lfsr[7:4] == 4'h0) ? 4'hF : m_lfsr[7:4];
          end else begin
            m_phase <= 1;
            m_ticks <= interval_of(m_issues);
          end
        end
        3: begin
          m_issues <= m_issues + 1;
          if (!bus.play_flag) m_phase <= 0;
          else if (m_expiry) m_phase <= 4;
          else begin m_phase <= 1; m_ticks <= interval_of(m_issues + 1); end
        end
        default: if (!bus.play_flag) m_phase <= 0;
      endcase
    end
  end

  // ---------------- compare + transaction monitor ----------------
  logic [21:0] got_v, exp_v;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmp_en) begin
      exp_v = {m_pulse, m_hex, 1'(m_phase == 4), 8'(interval_of(m_issues)), 5'(1 << m_phase)};
      got_v = {bus.break_pulse, bus.break_hex, bus.gameover_ctrl, bus.interval,
               bus.q_Over, bus.q_Issue, bus.q_Pick, bus.q_Count, bus.q_Idle};
      check("cycle_model", 32'(got_v), 32'(exp_v));
      if (bus.break_pulse != 4'h0) begin
        n_pulses++;
        hit_mask |= bus.break_pulse;
        $display("issue %0d: pulse=%b hex=%h interval=%0d t=%0t",
                 n_pulses, bus.break_pulse, bus.break_hex, bus.interval, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_tick();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.play_flag = 1'b0; bus.tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; n_pulses = 0; hit_mask = '0;
  endtask

  task automatic run_until(input int target, input int max_ticks, input string name);
    int t;
    t = 0;
    while (n_pulses < target && t < max_ticks) begin
      do_tick();
      t++;
    end
    check(name, 32'(n_pulses >= target), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; bus.tick = 1'b0; bus.play_flag = 1'b0; bus.broken = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_interval", 32'(bus.interval), 32'd8);
    check("rst_pulse", 32'(bus.break_pulse), 32'd0);
    check("rst_hex", 32'(bus.break_hex), 32'd0);
    check("rst_gameover", 32'(bus.gameover_ctrl), 32'd0);
    check("rst_idle", 32'(bus.q_Idle), 32'd1);
    rst_n = 1'b1; cmp_en = 1'b1;

    // Basic issue: pulse appears two clocks after the 8th tick.
    bus.play_flag = 1'b1;
    repeat (7) do_tick();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
    check("pick_after_8th", 32'(bus.q_Pick), 32'd1);
    check("pick_no_pulse", 32'(bus.break_pulse), 32'd0);
    @(negedge clk);
    check("issue_state", 32'(bus.q_Issue), 32'd1);
    check("issue_onehot", 32'($onehot(bus.break_pulse)), 32'd1);
    check("issue_hex_nz", 32'(bus.break_hex != 4'h0), 32'd1);
    @(negedge clk);
    check("pulse_one_cycle", 32'(bus.break_pulse), 32'd0);

    // Interval decay.
    run_until(3, 40, "reach_3_issues");
    check("interval_after_3", 32'(bus.interval), 32'd8);
    run_until(4, 20, "reach_4_issues");
    check("interval_after_4", 32'(bus.interval), 32'd7);
    run_until(24, 200, "reach_24_issues");
    check("interval_after_24", 32'(bus.interval), 32'd2);
    run_until(30, 60, "reach_30_issues");
    check("interval_floor", 32'(bus.interval), 32'd2);

    // Max broken: three broken stations block every issue.
    do_reset();
    bus.broken = 4'b0111; bus.play_flag = 1'b1;
    repeat (30) do_tick();
    check("skip_0111_no_pulse", 32'(n_pulses), 32'd0);
    bus.broken = 4'b0011; n_pulses = 0; hit_mask = '0;
    run_until(10, 150, "issues_with_0011");
    check("skip_0011_free_only", 32'(hit_mask & 4'b0011), 32'd0);

    // Game over after six all-broken ticks.
    do_reset();
    bus.broken = 4'hF; bus.play_flag = 1'b1;
    repeat (5) do_tick();
    check("no_over_after_5", 32'(bus.gameover_ctrl), 32'd0);
    do_tick();
    check("over_after_6", 32'(bus.gameover_ctrl), 32'd1);
    check("over_state", 32'(bus.q_Over), 32'd1);
    @(negedge clk) bus.play_flag = 1'b0;
    @(negedge clk);
    check("over_to_idle", 32'(bus.q_Idle), 32'd1);
    check("over_cleared", 32'(bus.gameover_ctrl), 32'd0);

    // Grace reset by a single not-all-broken cycle.
    do_reset();
    bus.broken = 4'hF; bus.play_flag = 1'b1;
    repeat (5) do_tick();
    @(negedge clk) bus.broken = 4'hE;
    @(negedge clk) bus.broken = 4'hF;
    repeat (5) do_tick();
    check("grace_reset_no_over", 32'(bus.gameover_ctrl), 32'd0);
    check("grace_reset_counting", 32'(bus.q_Count), 32'd1);
    do_tick();
    check("grace_resume_over", 32'(bus.gameover_ctrl), 32'd1);

    // Reset asserted while the pulse is out.
    do_reset();
    bus.broken = 4'h0; bus.play_flag = 1'b1;
    repeat (7) do_tick();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_pulse", 32'(bus.break_pulse != 4'h0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_pulse", 32'(bus.break_pulse), 32'd0);
    check("reset_to_idle", 32'(bus.q_Idle), 32'd1);
    @(negedge clk) begin rst_n = 1'b1; bus.play_flag = 1'b0; end

    // play_flag dropped during PICK.
    do_reset();
    bus.play_flag = 1'b1;
    repeat (7) do_tick();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) begin bus.tick = 1'b0; bus.play_flag = 1'b0; end
    check("abort_in_pick", 32'(bus.q_Pick), 32'd1);
    @(negedge clk);
    check("abort_to_idle", 32'(bus.q_Idle), 32'd1);
    check("abort_no_pulse_now", 32'(bus.break_pulse), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_pulse_ever", 32'(n_pulses), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule
